// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out (absolute priority) and a FIFO-buffered writer.
// Optional double buffering via FB_DBUF_EN (adds swap_req/bank and an extra ram_addr MSB).
module vga_fb_arbiter #(
   parameter int SCALE_LOG2 = 2,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int ADDR_W     = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              active_video,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [8:0]        wr_data,
`ifdef FB_DBUF_EN
   input  logic              swap_req,
   output logic              bank,
   output logic [ADDR_W:0]   ram_addr,
`else
   output logic [ADDR_W-1:0] ram_addr,
`endif
   output logic              ram_en,
   output logic              ram_we,
   output logic [8:0]        ram_wdata,
   input  logic [8:0]        ram_rdata,
   output logic              hsync,
   output logic              vsync,
   output logic [2:0]        red,
   output logic [2:0]        green,
   output logic [2:0]        blue
);
   localparam int FB_W = H_ACTIVE >> SCALE_LOG2;
   localparam int CELLS = FB_W * (V_ACTIVE >> SCALE_LOG2);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [9:0] SUB_MASK = 10'((1 << SCALE_LOG2) - 1);

   logic              run_q;
   logic [PW-1:0]     wp, rp;
   logic [PW:0]       count;
   logic [ADDR_W-1:0] fa [FIFO_DEPTH];
   logic [8:0]        fd [FIFO_DEPTH];
   logic              empty, full, push, pop, disp, in_range;
   logic [ADDR_W-1:0] rd_addr, head_addr, addr_lo;
   logic [1:0]        act_d, hs_d, vs_d;
   logic              rd_d1;
   logic [8:0]        pix_reg;

   assign empty     = count == '0;
   assign full      = count == (PW+1)'(FIFO_DEPTH);
   // run_q holds the arbiter idle for the first cycle after reset release
   assign wr_ready  = run_q && !full;
   assign push      = wr_valid && wr_ready;
   assign disp      = run_q && active_video && (x & SUB_MASK) == '0;
   assign pop       = run_q && !disp && !empty;
   assign head_addr = fa[rp];
   assign in_range  = 32'(head_addr) < CELLS;
   assign rd_addr   = ADDR_W'(32'(y >> SCALE_LOG2) * FB_W + 32'(x >> SCALE_LOG2));

   always_comb begin
      ram_en    = disp || (pop && in_range);
      ram_we    = !disp && pop && in_range;
      ram_wdata = ram_we ? fd[rp] : '0;
      addr_lo   = disp ? rd_addr : ram_we ? head_addr : '0;
   end

`ifdef FB_DBUF_EN
   logic swap_pend, vb_start;
   assign vb_start = run_q && y == 10'(V_ACTIVE) && x == '0;
   assign ram_addr = {disp ? bank : ram_we ? ~bank : 1'b0, addr_lo};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank      <= 1'b0;
         swap_pend <= 1'b0;
      end else begin
         if (vb_start && swap_pend) bank <= ~bank;
         swap_pend <= (swap_pend && !vb_start) || swap_req;
      end
   end
`else
   assign ram_addr = addr_lo;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         run_q <= 1'b1;
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fa[wp] <= wr_addr;
         fd[wp] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_d   <= '0;
         hs_d    <= 2'b11;
         vs_d    <= 2'b11;
         rd_d1   <= 1'b0;
         pix_reg <= '0;
      end else begin
         act_d <= {act_d[0], active_video};
         hs_d  <= {hs_d[0], hsync_in};
         vs_d  <= {vs_d[0], vsync_in};
         rd_d1 <= disp;
         if (rd_d1) pix_reg <= ram_rdata;
      end
   end

   assign hsync = hs_d[1];
   assign vsync = vs_d[1];
   assign {red, green, blue} = act_d[1] ? pix_reg : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for vga_fb_arbiter (SCALE_LOG2=2 main instance, SCALE_LOG2=0 blanking-drain instance).
module tb_vga_fb_arbiter;
   localparam int AW = 15;
   localparam int CELLS = 160 * 120;
`ifdef FB_DBUF_EN
   localparam int RAW = AW + 1;
`else
   localparam int RAW = AW;
`endif
   logic clk = 0, rst_n = 0;
   logic [9:0] x = 0, y = 0;
   logic active_video = 0, hsync_in = 1, vsync_in = 1;
   logic wr_valid = 0, wr_valid0 = 0, wr_ready, wr_ready0;
   logic [AW-1:0] wr_addr = 0;
   logic [8:0] wr_data = 0;
   logic ram_en, ram_we, ram_en0, ram_we0;
   logic [RAW-1:0] ram_addr, ram_addr0;
   logic [8:0] ram_wdata, ram_wdata0, ram_rdata = 0, rdata0 = 0;
   logic hsync, vsync, hsync0, vsync0;
   logic [2:0] red, green, blue, red0, green0, blue0;
`ifdef FB_DBUF_EN
   logic swap_req = 0, bank, bank0;
`endif
   int checks = 0, errors = 0, writes = 0;
   logic [8:0] mem [2**RAW];
   logic [AW+8:0] exp_q[$];
   logic [AW+8:0] e;

   vga_fb_arbiter dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active_video(active_video),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef FB_DBUF_EN
      .swap_req(swap_req), .bank(bank),
`endif
      .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
   );

   vga_fb_arbiter #(.SCALE_LOG2(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active_video(active_video),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_valid(wr_valid0), .wr_ready(wr_ready0),
      .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef FB_DBUF_EN
      .swap_req(swap_req), .bank(bank0),
`endif
      .ram_addr(ram_addr0), .ram_en(ram_en0), .ram_we(ram_we0), .ram_wdata(ram_wdata0),
      .ram_rdata(rdata0), .hsync(hsync0), .vsync(vsync0), .red(red0), .green(green0), .blue(blue0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
      if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
   end

   // Write scoreboard: accepted in-range requests must reach RAM in order
   always @(posedge clk) begin
      if (!rst_n) exp_q.delete();
      else begin
         if (ram_en && ram_we) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", ram_addr, ram_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({ram_addr[AW-1:0], ram_wdata} !== e) begin
                  errors++;
                  $display("FAIL wr_order: got addr=%h data=%h, expected addr=%h data=%h",
                           ram_addr[AW-1:0], ram_wdata, e[AW+8:9], e[8:0]);
               end
            end
         end
         if (wr_valid && wr_ready && int'(wr_addr) < CELLS) exp_q.push_back({wr_addr, wr_data});
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      rst_n = 1;
      tick();
      active_video = 1; x = 0; hsync_in = 0; vsync_in = 0; wr_valid = 1;
      for (int i = 0; i < 4; i++) begin
         wr_addr = AW'(100 + i); wr_data = 9'(i + 1);
         tick();
      end
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_full_ready: got %b expected 0", wr_ready); end
      rst_n = 0;
      #1;
      checks++;
      if ({ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
         errors++; $display("FAIL rst_ram: got en=%b we=%b addr=%h wdata=%h expected all 0", ram_en, ram_we, ram_addr, ram_wdata);
      end
      checks++;
      if ({red, green, blue, hsync, vsync} !== {9'h0, 2'b11}) begin
         errors++; $display("FAIL rst_pix: got rgb=%h hs=%b vs=%b expected rgb=0 hs=1 vs=1", {red, green, blue}, hsync, vsync);
      end
      tick(); tick();
      rst_n = 1; active_video = 0; wr_valid = 0; hsync_in = 1; vsync_in = 1;
      tick();
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", wr_ready); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_stale_write: got we=%b expected 0", ram_we); end
         tick();
      end
   endtask

   task automatic test_scanout();
      int w0;
      logic [8:0] exp_rgb;
      tick();
      w0 = writes;
      active_video = 0; wr_valid = 1; wr_addr = 0; wr_data = 9'h1FF;
      tick();
      wr_addr = 1; wr_data = 9'h049;
      tick();
      wr_valid = 0;
      repeat (4) tick();
      checks++;
      if (writes - w0 !== 2) begin errors++; $display("FAIL preload_writes: got %0d expected 2", writes - w0); end
      y = 0;
      for (int i = 0; i < 12; i++) begin
         x = 10'(i); active_video = i < 8; hsync_in = i != 3;
         @(negedge clk);
         if (i < 8) begin
            checks++;
            if ((ram_en && !ram_we) !== (i % 4 == 0)) begin
               errors++; $display("FAIL disp_slot x=%0d: got read=%b expected %b", i, ram_en && !ram_we, i % 4 == 0);
            end
         end
         exp_rgb = (i >= 2 && i < 10) ? (i < 6 ? 9'h1FF : 9'h049) : 9'h0;
         checks++;
         if ({red, green, blue} !== exp_rgb) begin
            errors++; $display("FAIL rgb cycle=%0d: got %h expected %h", i, {red, green, blue}, exp_rgb);
         end
         checks++;
         if (hsync !== (i != 5)) begin errors++; $display("FAIL hsync_delay cycle=%0d: got %b expected %b", i, hsync, i != 5); end
         tick();
      end
      hsync_in = 1;
   endtask

   task automatic test_contention();
      int k = 0, w0;
      logic hs;
      tick();
      w0 = writes;
      active_video = 1; y = 0;
      for (int c = 0; c < 200; c++) begin
         x = 10'(c); wr_valid = k < 10; wr_addr = AW'(k); wr_data = 9'(k * 37 + 5);
         @(negedge clk);
         if (ram_we) begin
            checks++;
            if (x[1:0] == 2'b00) begin errors++; $display("FAIL contention_slot: got write at x=%0d expected none on DISP slot", x); end
         end
         checks++;
         if (exp_q.size() > 4 || (exp_q.size() == 4 && wr_ready)) begin
            errors++; $display("FAIL contention_fifo: got occupancy=%0d ready=%b expected <=4 and ready=0 when full", exp_q.size(), wr_ready);
         end
         hs = wr_valid && wr_ready;
         tick();
         if (hs) k++;
         if (k == 10 && exp_q.size() == 0) break;
      end
      wr_valid = 0;
      checks++;
      if (k !== 10 || exp_q.size() !== 0 || writes - w0 !== 10) begin
         errors++; $display("FAIL contention_done: got pushed=%0d pending=%0d written=%0d expected 10/0/10", k, exp_q.size(), writes - w0);
      end
   endtask

   task automatic test_blank_drain();
      tick();
      active_video = 1; x = 3; wr_valid0 = 1;
      for (int i = 0; i < 4; i++) begin
         wr_addr = AW'(200 + i); wr_data = 9'(i + 9);
         @(negedge clk);
         checks++;
         if (wr_ready0 !== 1'b1 || ram_we0 !== 1'b0) begin
            errors++; $display("FAIL drain_fill i=%0d: got ready=%b we=%b expected 1/0", i, wr_ready0, ram_we0);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (wr_ready0 !== 1'b0 || ram_we0 !== 1'b0) begin
         errors++; $display("FAIL drain_full: got ready=%b we=%b expected 0/0", wr_ready0, ram_we0);
      end
      wr_valid0 = 0;
      tick();
      active_video = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (ram_we0 !== (i < 4) || (i < 4 && ram_addr0[AW-1:0] !== AW'(200 + i))) begin
            errors++; $display("FAIL drain_blank i=%0d: got we=%b addr=%0d expected we=%b addr=%0d", i, ram_we0, ram_addr0[AW-1:0], i < 4, 200 + i);
         end
         tick();
      end
   endtask

   task automatic test_full_push_pop();
      int w0;
      tick();
      w0 = writes;
      active_video = 1; x = 0; wr_valid = 1;
      for (int i = 0; i < 4; i++) begin
         wr_addr = AW'(300 + i); wr_data = 9'(i + 20);
         tick();
      end
      wr_addr = AW'(304); wr_data = 9'h155; x = 1;
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b0 || ram_we !== 1'b1 || exp_q.size() !== 4) begin
         errors++; $display("FAIL full_pushpop: got ready=%b we=%b count=%0d expected 0/1/4", wr_ready, ram_we, exp_q.size());
      end
      tick();
      x = 0;
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b1 || exp_q.size() !== 3) begin
         errors++; $display("FAIL full_after_pop: got ready=%b count=%0d expected 1/3", wr_ready, exp_q.size());
      end
      tick();
      wr_valid = 0; active_video = 0;
      repeat (6) tick();
      checks++;
      if (exp_q.size() !== 0 || writes - w0 !== 5) begin
         errors++; $display("FAIL full_drain: got pending=%0d written=%0d expected 0/5", exp_q.size(), writes - w0);
      end
   endtask

   task automatic test_out_of_range();
      int w0;
      tick();
      w0 = writes;
      active_video = 0; wr_valid = 1; wr_addr = AW'(CELLS); wr_data = 9'h1AA;
      tick();
      wr_addr = 7; wr_data = 9'h0F0;
      tick();
      wr_valid = 0;
      repeat (4) tick();
      checks++;
      if (writes - w0 !== 1) begin errors++; $display("FAIL out_of_range: got %0d writes expected 1", writes - w0); end
   endtask

`ifdef FB_DBUF_EN
   task automatic test_dbuf();
      tick();
      active_video = 0; y = 100; x = 5; swap_req = 1;
      tick();
      swap_req = 0; y = 200;
      tick();
      y = 480; x = 0;
      @(negedge clk);
      checks++;
      if (bank !== 1'b0) begin errors++; $display("FAIL dbuf_before: got bank=%b expected 0", bank); end
      tick();
      y = 481;
      @(negedge clk);
      checks++;
      if (bank !== 1'b1) begin errors++; $display("FAIL dbuf_after: got bank=%b expected 1", bank); end
      tick();
      active_video = 1; y = 0; x = 0;
      @(negedge clk);
      checks++;
      if (!(ram_en && !ram_we) || ram_addr[AW] !== 1'b1) begin
         errors++; $display("FAIL dbuf_read_msb: got en=%b we=%b msb=%b expected 1/0/1", ram_en, ram_we, ram_addr[AW]);
      end
      tick();
      active_video = 0; wr_valid = 1; wr_addr = 5; wr_data = 9'h0AA;
      tick();
      wr_valid = 0;
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b1 || ram_addr[AW] !== 1'b0) begin
         errors++; $display("FAIL dbuf_write_msb: got we=%b msb=%b expected 1/0", ram_we, ram_addr[AW]);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_scanout();
      test_contention();
      test_blank_drain();
      test_full_push_pop();
      test_out_of_range();
`ifdef FB_DBUF_EN
      test_dbuf();
`endif
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
